// File: rtl/image_frame_loader.sv
`timescale 1ns/1ps
// Frame buffer: assembles an IMG_W x IMG_H binary image from CHUNK_W-bit beats, then holds it for row reads until released.
// Optional per-beat even-parity check is enabled by defining LOADER_PARITY_EN.
module image_frame_loader #(
  parameter int IMG_W   = 14,
  parameter int IMG_H   = 14,
  parameter int CHUNK_W = 7,
  localparam int NBEATS = (IMG_W / CHUNK_W) * IMG_H,
  localparam int RW     = $clog2(IMG_H),
  localparam int CW     = $clog2(NBEATS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [CHUNK_W-1:0] in_data,
`ifdef LOADER_PARITY_EN
  input  logic               in_parity,
`endif
  output logic               in_ready,
  output logic               frame_valid,
  input  logic               frame_release,
  input  logic [RW-1:0]      rd_row_idx,
  output logic [IMG_W-1:0]   rd_row,
  output logic [CW-1:0]      beat_cnt,
  output logic               err_sof,
  output logic               err_nosof,
  input  logic               err_clr,
  output logic               err_parity
);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             cnt_nxt;
  logic [CW-1:0]             wr_idx;
  logic                      wr_en;
  logic                      accept;
  logic                      parity_bad;
  logic                      sof_evt, nosof_evt;
  logic [IMG_W*IMG_H-1:0]    frame;

  assign in_ready    = (state != FULL);
  assign frame_valid = (state == FULL);
  assign accept      = in_valid & in_ready;

`ifdef LOADER_PARITY_EN
  logic par_q;
  assign parity_bad = accept & (^{in_data, in_parity});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          par_q <= 1'b0;
    else if (parity_bad) par_q <= 1'b1;
    else if (err_clr)    par_q <= 1'b0;
  end
  assign err_parity = par_q;
`else
  assign parity_bad = 1'b0;
  assign err_parity = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = beat_cnt;
    wr_en     = 1'b0;
    wr_idx    = beat_cnt;
    sof_evt   = 1'b0;
    nosof_evt = 1'b0;
    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          if (parity_bad) begin
            // A corrupt beat abandons the frame regardless of framing.
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (in_sof) begin
            wr_en     = 1'b1;
            wr_idx    = '0;
            cnt_nxt   = CW'(1);
            sof_evt   = (state == LOAD);
            state_nxt = (NBEATS == 1) ? FULL : LOAD;
          end else if (state == IDLE) begin
            nosof_evt = 1'b1;
          end else begin
            wr_en   = 1'b1;
            cnt_nxt = beat_cnt + CW'(1);
            if (beat_cnt == CW'(NBEATS - 1)) state_nxt = FULL;
          end
        end
      end
      FULL: begin
        if (frame_release) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      err_sof   <= 1'b0;
      err_nosof <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      // Error events take priority over a same-cycle clear.
      if (sof_evt)      err_sof <= 1'b1;
      else if (err_clr) err_sof <= 1'b0;
      if (nosof_evt)    err_nosof <= 1'b1;
      else if (err_clr) err_nosof <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) frame[int'(wr_idx)*CHUNK_W +: CHUNK_W] <= in_data;
  end

  always_comb begin
    rd_row = '0;
    if (int'(rd_row_idx) < IMG_H) rd_row = frame[int'(rd_row_idx)*IMG_W +: IMG_W];
  end

endmodule

// File: tb/tb_image_frame_loader.sv
`timescale 1ns/1ps
// Directed self-checking bench for image_frame_loader (14x14 image, 7-bit beats, 28 beats/frame).
module tb_image_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [6:0]  in_data = '0;
  logic        in_ready;
  logic        frame_valid;
  logic        frame_release = 1'b0;
  logic [3:0]  rd_row_idx = '0;
  logic [13:0] rd_row;
  logic [4:0]  beat_cnt;
  logic        err_sof, err_nosof, err_parity;
  logic        err_clr = 1'b0;
`ifdef LOADER_PARITY_EN
  logic        in_parity = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  image_frame_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
`ifdef LOADER_PARITY_EN
    .in_parity(in_parity),
`endif
    .in_ready(in_ready), .frame_valid(frame_valid), .frame_release(frame_release),
    .rd_row_idx(rd_row_idx), .rd_row(rd_row), .beat_cnt(beat_cnt),
    .err_sof(err_sof), .err_nosof(err_nosof), .err_clr(err_clr), .err_parity(err_parity)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat for exactly one clock edge; leaves time at posedge+1.
  task automatic send_beat(input logic [6:0] d, input logic sof, input logic bad_par);
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
`ifdef LOADER_PARITY_EN
    in_parity = (^d) ^ bad_par;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic release_frame();
    frame_release = 1'b1;
    @(posedge clk); #1;
    frame_release = 1'b0;
  endtask

  task automatic read_row(input logic [3:0] r);
    rd_row_idx = r;
    #1;
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_errs", {err_sof, err_nosof, err_parity}, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: full frame, data = beat index
    for (int i = 0; i < 27; i++) send_beat(7'(i), i == 0, 1'b0);
    check("t1_not_full_yet", frame_valid, 0);
    check("t1_cnt27", beat_cnt, 27);
    send_beat(7'd27, 1'b0, 1'b0);
    check("t1_frame_valid", frame_valid, 1);
    check("t1_cnt28", beat_cnt, 28);
    read_row(4'd0);
    check("t1_row0", rd_row, 14'h0080);
    read_row(4'd13);
    check("t1_row13", rd_row, {7'd27, 7'd26});
    read_row(4'd14);
    check("t1_row_oob", rd_row, 0);

    // 2: backpressure while FULL, then release with a beat still offered
    in_valid = 1'b1; in_data = 7'h7f;
    repeat (2) @(posedge clk);
    #1;
    check("t2_in_ready_full", in_ready, 0);
    check("t2_cnt_held", beat_cnt, 28);
    release_frame();
    in_valid = 1'b0;
    check("t2_rel_fv", frame_valid, 0);
    check("t2_rel_ready", in_ready, 1);
    check("t2_rel_cnt", beat_cnt, 0);
    check("t2_no_bypass", err_nosof, 0);

    // 3: resync after 10 beats
    for (int i = 0; i < 10; i++) send_beat(7'(i + 1), i == 0, 1'b0);
    check("t3_cnt10", beat_cnt, 10);
    send_beat(7'h55, 1'b1, 1'b0);
    check("t3_resync_cnt", beat_cnt, 1);
    check("t3_err_sof", err_sof, 1);
    for (int i = 0; i < 27; i++) send_beat(7'h2a, 1'b0, 1'b0);
    check("t3_frame_valid", frame_valid, 1);
    read_row(4'd0);
    check("t3_row0_lo", rd_row[6:0], 7'h55);
    check("t3_row0_hi", rd_row[13:7], 7'h2a);
    release_frame();

    // 4: beats without SOF in IDLE, error clear priority
    for (int i = 0; i < 3; i++) send_beat(7'h11, 1'b0, 1'b0);
    check("t4_err_nosof", err_nosof, 1);
    check("t4_cnt0", beat_cnt, 0);
    check("t4_idle_fv", frame_valid, 0);
    err_clr = 1'b1;
    send_beat(7'h12, 1'b0, 1'b0);
    check("t4_evt_beats_clr", err_nosof, 1);
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("t4_clr_nosof", err_nosof, 0);
    check("t4_clr_sof", err_sof, 0);

    // 5: asynchronous reset mid-frame
    for (int i = 0; i < 15; i++) send_beat(7'(i), i == 0, 1'b0);
    check("t5_cnt15", beat_cnt, 15);
    #3 rst_n = 1'b0;
    #1;
    check("t5_async_cnt", beat_cnt, 0);
    check("t5_async_ready", in_ready, 1);
    check("t5_async_fv", frame_valid, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 28; i++) send_beat(7'(i + 3), i == 0, 1'b0);
    check("t5_reload_fv", frame_valid, 1);
    read_row(4'd5);
    check("t5_row5", rd_row, {7'd14, 7'd13});
    check("t5_no_parity_err", err_parity, 0);
    release_frame();

`ifdef LOADER_PARITY_EN
    // 6: corrupt parity on beat 5 abandons the frame
    for (int i = 0; i < 6; i++) send_beat(7'(i + 9), i == 0, i == 5);
    check("t6_err_parity", err_parity, 1);
    check("t6_cnt0", beat_cnt, 0);
    check("t6_idle", in_ready & ~frame_valid, 1);
    for (int i = 0; i < 28; i++) send_beat(7'(i + 40), i == 0, 1'b0);
    check("t6_clean_fv", frame_valid, 1);
    read_row(4'd1);
    check("t6_row1", rd_row, {7'd43, 7'd42});
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
